// File: rtl/uart_pkg.sv
// Shared types and helpers for the console UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    // Rounded to the nearest whole clock so the bit period error stays below half a clock.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read: o_data shows the head entry whenever
// the FIFO is non-empty, so a pop consumes it in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_level = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO; back-to-back frames are sent with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 921_600,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo needs at least 2 clocks per bit");
    end

    uart_tx_state_e              state_q;
    logic [BAUD_W-1:0]           baud_q;
    logic [2:0]                  bit_idx_q;
    logic [UART_DATA_BITS-1:0]   shift_q;
    logic                        tx_q;

    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [LVL_W-1:0] fifo_level;
    logic             baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_level)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    // A byte leaves the FIFO when the line is idle or exactly as a stop bit expires.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty && (state_q == IDLE || (state_q == STOP && baud_done))) begin
            fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (fifo_pop) begin
                        shift_q <= fifo_data;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_data;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx    = tx_q;
    assign o_busy       = (state_q != IDLE) | ~fifo_empty;
    assign o_ready      = ~fifo_full & ~i_rst;
    assign o_fifo_level = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames, the main thread checks timing.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 109;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       uart_tx;
    logic       busy;
    logic [4:0] level;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          frame_err = 0;
    int unsigned last_accept = 0;
    logic [7:0]  rx_q[$];
    int unsigned start_q[$];

    uart_tx_fifo #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD_RATE   (921_600),
        .FIFO_DEPTH  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_uart_tx    (uart_tx),
        .o_busy       (busy),
        .o_fifo_level (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receive monitor: samples each bit at its centre, records start-bit cycle and decoded byte.
    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !uart_tx) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                if (uart_tx) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (!uart_tx) frame_err++;
                rx_q.push_back(b);
            end
            prev = rst ? 1'b1 : uart_tx;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int k;
        k = 0;
        data  = b;
        valid = 1'b1;
        while (!ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            check("push_timeout", 32'(ready), 32'd1);
            valid = 1'b0;
            return;
        end
        @(negedge clk);
        last_accept = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic check_start(input string tag, input int unsigned exp);
        int unsigned got;
        got = (start_q.size() > 0) ? start_q.pop_front() : 0;
        check(tag, got, exp);
    endtask

    task automatic wait_idle(output int unsigned at);
        int k;
        k = 0;
        while (busy && k < 30000) begin
            @(negedge clk);
            k++;
        end
        at = cyc;
    endtask

    task automatic wait_cyc(input int unsigned target);
        int k;
        k = 0;
        while (cyc < target && k < 100000) begin
            @(negedge clk);
            k++;
        end
        check("wait_cyc", cyc, target);
    endtask

    logic [7:0] hi_bytes [3];
    logic [7:0] pp_bytes [5];

    initial begin : main
        int unsigned s0, t_idle, cnt;
        int          err_before;
        hi_bytes = '{8'h48, 8'h69, 8'h0A};
        pp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};

        // Reset and release
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(ready), 32'd0);
        check("tx_in_reset", 32'(uart_tx), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rel_tx", 32'(uart_tx), 32'd1);
        check("rel_ready", 32'(ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_level", 32'(level), 32'd0);

        // Single byte 0x55: latency and bit widths
        push_byte(8'h55);
        s0 = last_accept + 1;
        check("acc_tx_idle", 32'(uart_tx), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("start_latency", 32'(uart_tx), 32'd0);
        cnt = 1;
        while (!uart_tx && cnt < 1000) begin
            @(negedge clk);
            if (!uart_tx) cnt++;
        end
        check("start_bit_len", cnt, CPB);
        cnt = 1;
        while (uart_tx && cnt < 1000) begin
            @(negedge clk);
            if (uart_tx) cnt++;
        end
        check("bit0_len", cnt, CPB);
        wait_rx(1, 2 * FRAME);
        check_rx("rx_55", 8'h55);
        check_start("start_55", s0);
        wait_idle(t_idle);
        check("idle_55", t_idle, s0 + FRAME);

        // "Hi\n" back-to-back, no idle gap between frames
        foreach (hi_bytes[i]) begin
            push_byte(hi_bytes[i]);
            if (i == 0) s0 = last_accept + 1;
        end
        wait_rx(3, 4 * FRAME);
        foreach (hi_bytes[i]) begin
            check_rx("rx_hi", hi_bytes[i]);
            check_start("start_hi", s0 + i * FRAME);
        end
        wait_idle(t_idle);
        check("busy_drop_hi", t_idle, s0 + 3 * FRAME);
        check("busy_after_hi", 32'(busy), 32'd0);

        // 18 bytes against a 16-entry FIFO
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h40 + 8'(i));
            if (i == 0) s0 = last_accept + 1;
        end
        check("full_level", 32'(level), 32'd16);
        check("full_ready", 32'(ready), 32'd0);
        push_byte(8'h51);
        check("refill_time", last_accept, s0 + FRAME + 1);
        check("refill_level", 32'(level), 32'd16);
        wait_rx(18, 19 * FRAME);
        for (int i = 0; i < 18; i++) check_rx("rx_burst", 8'h40 + 8'(i));
        wait_idle(t_idle);
        check("busy_drop_burst", t_idle, s0 + 18 * FRAME);
        start_q.delete();

        // Push and pop on the same edge with level 3
        for (int i = 0; i < 4; i++) begin
            push_byte(pp_bytes[i]);
            if (i == 0) s0 = last_accept + 1;
        end
        check("pp_level_before", 32'(level), 32'd3);
        wait_cyc(s0 + FRAME - 1);
        check("pp_level_pre_edge", 32'(level), 32'd3);
        data  = pp_bytes[4];
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("pp_level_same", 32'(level), 32'd3);
        wait_rx(5, 6 * FRAME);
        foreach (pp_bytes[i]) check_rx("rx_pp", pp_bytes[i]);
        wait_idle(t_idle);
        check("busy_drop_pp", t_idle, s0 + 5 * FRAME);
        check("frame_err", frame_err, 0);
        start_q.delete();

        // Reset during bit 1 (a 0) of 0xA5 with another byte queued
        push_byte(8'hA5);
        s0 = last_accept + 1;
        push_byte(8'h3C);
        check("rst_level_before", 32'(level), 32'd1);
        wait_cyc(s0 + 2 * CPB + 40);
        check("a5_bit1", 32'(uart_tx), 32'd0);
        err_before = frame_err;
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);
        cnt = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (!uart_tx) cnt++;
        end
        check("post_rst_low", cnt, 0);
        check("post_rst_starts", start_q.size(), 1);
        check("post_rst_frames", 32'(rx_q.size() <= 1), 32'd1);
        check("post_rst_errs", 32'((frame_err - err_before) <= 1), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
